// File: rtl/fifo_req_arb.sv
// Front-end arbiter for the 32-entry SRAM FIFO: one-hot push/pop grants from
// valid/ready streams, with a 2-entry buffer that catches SRAM read data.
module fifo_req_arb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              push,
  output logic              pop,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  input  logic              ctr_error,
  output logic [5:0]        count,
  output logic              arb_err
);

  localparam int unsigned CNT_W = 6;

  logic              prio;
  logic              rd_pend;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] rbuf0;
  logic [DATA_W-1:0] rbuf1;

  logic       pop_want;
  logic       push_ok;
  logic       contend;
  logic       buf_rd;
  logic       wrap;
  logic [1:0] buf_cnt_rd;

  // Grant logic; the in-flight read is counted so the buffer can never overflow.
  always_comb begin
    pop_want   = 1'b0;
    push_ok    = 1'b0;
    in_ready   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    contend    = 1'b0;
    wrap       = 1'b0;
    pop_want   = (count != '0) &&
                 (({1'b0, buf_cnt} + {2'b00, rd_pend}) < 3'd2);
    push_ok    = (count != CNT_W'(DEPTH));
    if (!rst) begin
      in_ready = push_ok && !(pop_want && prio);
      push     = in_valid && in_ready;
      pop      = pop_want && !push;
    end
    contend    = in_valid && push_ok && pop_want;
    wrap       = (push && (count == CNT_W'(DEPTH))) || (pop && (count == '0));
  end

  assign out_valid  = (buf_cnt != 2'd0) && !rst;
  assign out_data   = rbuf0;
  assign sram_d     = in_data;
  assign buf_rd     = out_valid && out_ready;
  assign buf_cnt_rd = buf_cnt - 2'(buf_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      prio    <= 1'b0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
      rbuf0   <= '0;
      rbuf1   <= '0;
      arb_err <= 1'b0;
    end else begin
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      rd_pend <= pop;
      if (contend) prio <= ~prio;
      buf_cnt <= buf_cnt + 2'(rd_pend) - 2'(buf_rd);
      if (buf_rd) rbuf0 <= rbuf1;
      // Returning word lands behind whatever survives this cycle's read.
      if (rd_pend) begin
        if (buf_cnt_rd == 2'd0) rbuf0 <= sram_q;
        else                    rbuf1 <= sram_q;
      end
      if (ctr_error || (push && pop) || wrap) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_req_arb.sv
// Bench for fifo_req_arb: SRAM stand-in, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_req_arb;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          ctr_error = 1'b0;
  logic [DW-1:0] sram_q = '0;
  logic          in_ready, out_valid, push, pop, arb_err;
  logic [DW-1:0] out_data, sram_d;
  logic [5:0]    count;

  always #5 clk = ~clk;

  fifo_req_arb #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .push(push), .pop(pop), .sram_d(sram_d), .sram_q(sram_q),
    .ctr_error(ctr_error), .count(count), .arb_err(arb_err)
  );

  // SRAM + fifo_ctr stand-in: read word appears the cycle after pop.
  logic [DW-1:0] mem[$];
  always @(posedge clk) begin
    if (rst) mem.delete();
    else begin
      if (push) mem.push_back(sram_d);
      if (pop && mem.size() > 0) sram_q <= mem.pop_front();
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  int            mcount = 0;
  bit            mprio = 0, mpend = 0, merr = 0;
  logic [DW-1:0] inflight = '0;
  logic [DW-1:0] mfifo[$];
  logic [DW-1:0] obuf[$];
  logic [DW-1:0] sb[$];
  int            n_pop = 0, n_out = 0;

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit pw = 0, pok = 0, e_ready = 0, e_push = 0, e_pop = 0, e_ov = 0;
    @(negedge clk);
    if (!rst) begin
      pok     = (mcount != DEPTH);
      pw      = (mcount != 0) && ((obuf.size() + int'(mpend)) < 2);
      e_ready = pok && !(pw && mprio);
      e_push  = in_valid && e_ready;
      e_pop   = pw && !e_push;
      e_ov    = (obuf.size() != 0);
    end
    chk("in_ready", in_ready, e_ready);
    chk("push", push, e_push);
    chk("pop", pop, e_pop);
    chk("onehot", push & pop, 0);
    chk("out_valid", out_valid, e_ov);
    chk("count", count, mcount);
    chk("arb_err", arb_err, merr);
    chk("sram_d", sram_d, in_data);
    if (e_ov && out_valid) chk("out_data", out_data, obuf[0]);
    if (rst) begin
      mcount = 0; mprio = 0; mpend = 0; merr = 0;
      mfifo.delete(); obuf.delete(); sb.delete();
    end else begin
      if (e_ov && out_ready) begin
        void'(obuf.pop_front());
        n_out++;
        if (sb.size() > 0) chk("order", out_data, sb.pop_front());
      end
      if (mpend) obuf.push_back(inflight);
      if (e_push) begin
        mfifo.push_back(in_data);
        sb.push_back(in_data);
      end
      if (e_pop && mfifo.size() > 0) begin
        inflight = mfifo.pop_front();
        n_pop++;
      end
      mpend  = e_pop;
      mcount = mcount + int'(e_push) - int'(e_pop);
      if (in_valid && pok && pw) mprio = !mprio;
      if (ctr_error) merr = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = push;
      cycle();
    end
    in_valid = 1'b0;
    if (!ok) chk("put_timeout", 0, 1);
  endtask

  initial begin
    bit p, prev_p, seen;
    int out0;

    // Reset, then idle
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    #1;
    chk("idle_count", count, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_push", push, 0);
    chk("idle_pop", pop, 0);
    chk("idle_arb_err", arb_err, 0);
    cycle();

    // Single word: push C0, pop C1, count 0 in C2, data out in C3
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    #1 chk("c0_push", push, 1);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("c1_pop", pop, 1);
    chk("c1_count", count, 1);
    cycle();
    #1;
    chk("c2_count", count, 0);
    chk("c2_out_valid", out_valid, 0);
    cycle();
    #1;
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_data", out_data, 8'hA5);
    repeat (3) cycle();

    // Fill: buffer pre-filled so nothing pops, then 32 writes
    out_ready = 1'b0;
    put(8'h10); put(8'h11);
    repeat (6) cycle();
    #1;
    chk("pre_out_valid", out_valid, 1);
    chk("pre_count", count, 0);
    for (int i = 0; i < 32; i++) put(8'h20 + 8'(i));
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("full_count", count, 32);
    chk("full_in_ready", in_ready, 0);
    chk("full_push", push, 0);
    chk("full_arb_err", arb_err, 0);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (80) cycle();
    #1;
    chk("fill_drain_count", count, 0);
    chk("fill_drain_left", sb.size(), 0);

    // Contention at count 4: grants alternate
    out_ready = 1'b0;
    put(8'h30); put(8'h31);
    repeat (6) cycle();
    for (int i = 0; i < 4; i++) put(8'h40 + 8'(i));
    #1 chk("cont_count", count, 4);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_p    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h50 + 8'(i);
      #1 p = push;
      if (i >= 1) chk("cont_one_grant", int'(push ^ pop), 1);
      if (i >= 2) chk("cont_alternate", p, !prev_p);
      prev_p = p;
      cycle();
    end
    in_valid = 1'b0;
    repeat (60) cycle();
    #1;
    chk("cont_drain_count", count, 0);
    chk("cont_drain_left", sb.size(), 0);

    // Backpressure: 10 writes, out_ready low -> exactly 2 pops
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b0;
    n_pop = 0;
    for (int i = 0; i < 10; i++) put(8'h60 + 8'(i));
    repeat (10) cycle();
    #1;
    chk("bp_pops", n_pop, 2);
    chk("bp_count", count, 8);
    chk("bp_out_valid", out_valid, 1);
    out0 = n_out;
    out_ready = 1'b1;
    repeat (40) cycle();
    #1;
    chk("bp_words_out", n_out - out0, 10);
    chk("bp_drain_count", count, 0);
    chk("bp_drain_left", sb.size(), 0);

    // Sticky error
    ctr_error = 1'b1;
    cycle();
    ctr_error = 1'b0;
    repeat (3) cycle();
    #1 chk("err_sticky", arb_err, 1);

    // Reset with a read in flight
    put(8'h70);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1 seen = pop;
      cycle();
    end
    chk("pend_seen", seen, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_arb_err", arb_err, 0);
    cycle();
    #1 chk("rst_no_bufwr", out_valid, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
